// File: rtl/affine_subblk_sched.sv
// Sequences reference fetch, interpolation filter and Hadamard per 4x4 sub-block of one CU
// and accumulates the SATD of all sub-blocks for a single affine mode.
module affine_subblk_sched #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [5:0]        num_of_sub_blk,
    input  logic              mode_6param,
    input  logic              abort,
    output logic              ref_req,
    output logic [5:0]        ref_blk_idx,
    input  logic              ref_gnt,
    output logic              filt_start,
    input  logic              filt_done,
    output logic              had_start,
    input  logic              had_done,
    input  logic [DATA_W-1:0] had_satd,
    output logic              busy,
    output logic              done,
    output logic [21:0]       had_sum,
    output logic              result_6param
);
    localparam int SUM_W = 22;

    typedef enum logic [2:0] {IDLE, FETCH, FILTER, HAD, DONE} state_t;

    state_t     state, nxt;
    logic [5:0] cnt_q;
    logic       accept, active, sum_hit, last_blk;
    logic       ref_req_d, filt_start_d, had_start_d, busy_d, done_d;

    function automatic logic [SUM_W-1:0] acc_add(input logic [SUM_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return a + SUM_W'(b);
    endfunction

    assign accept   = (state == IDLE) && start;
    assign active   = (state == FETCH) || (state == FILTER) || (state == HAD);
    assign last_blk = ((ref_blk_idx + 6'd1) == cnt_q);
    // filt_start/had_start double as "first cycle of state" flags for ignoring early responses
    assign sum_hit  = (state == HAD) && !abort && !had_start && had_done;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = (num_of_sub_blk != 6'd0) ? FETCH : DONE;
            FETCH:   if (abort) nxt = IDLE;
                     else if (ref_gnt) nxt = FILTER;
            FILTER:  if (abort) nxt = IDLE;
                     else if (!filt_start && filt_done) nxt = HAD;
            HAD:     if (abort) nxt = IDLE;
                     else if (!had_start && had_done) nxt = last_blk ? DONE : FETCH;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        ref_req_d    = (nxt == FETCH);
        filt_start_d = (nxt == FILTER) && (state != FILTER);
        had_start_d  = (nxt == HAD) && (state != HAD);
        busy_d       = (nxt == FETCH) || (nxt == FILTER) || (nxt == HAD);
        done_d       = (nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            ref_req       <= 1'b0;
            filt_start    <= 1'b0;
            had_start     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            ref_blk_idx   <= 6'd0;
            cnt_q         <= 6'd0;
            had_sum       <= '0;
            result_6param <= 1'b0;
        end else begin
            state      <= nxt;
            ref_req    <= ref_req_d;
            filt_start <= filt_start_d;
            had_start  <= had_start_d;
            busy       <= busy_d;
            done       <= done_d;
            if (accept) begin
                cnt_q         <= num_of_sub_blk;
                result_6param <= mode_6param;
                had_sum       <= '0;
                ref_blk_idx   <= 6'd0;
            end else if (active && abort) begin
                had_sum <= '0;
            end else if (sum_hit) begin
                had_sum <= acc_add(had_sum, had_satd);
                if (!last_blk) ref_blk_idx <= ref_blk_idx + 6'd1;
            end
        end
    end
endmodule
